// File: rtl/unidade_controle_jogo_exp8_pkg.sv
// Shared definitions for the memory-game (Genius) control unit.
// Holds the state codes (also shown on the 7-segment debug display)
// and the Moore output decode.
// Optional feature macro: TIMEOUT_EN (player-move timeout path).
package unidade_controle_jogo_exp8_pkg;

  localparam int unsigned TIMER_W = 12;

  typedef enum logic [4:0] {
    INICIAL        = 5'h00,
    PREPARACAO     = 5'h01,
    INICIA_RODADA  = 5'h02,
    MOSTRA         = 5'h03,
    INTERVALO      = 5'h04,
    PROXIMO_MOSTRA = 5'h05,
    INICIA_JOGADAS = 5'h06,
    ESPERA_JOGADA  = 5'h07,
    REGISTRA       = 5'h08,
    COMPARACAO     = 5'h09,
    PROXIMA_JOGADA = 5'h0A,
    ULTIMA_RODADA  = 5'h0B,
    PROXIMA_RODADA = 5'h0C,
    FIM_GANHOU     = 5'h0D,
    FIM_PERDEU     = 5'h0E,
    FIM_TIMEOUT    = 5'h0F
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraR;
    logic contaR;
    logic zeraRJ;
    logic registraRJ;
    logic mostra_mem;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  // Moore output decode of a state code.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zeraE  = 1'b1;
        s.zeraR  = 1'b1;
        s.zeraRJ = 1'b1;
      end
      INICIA_RODADA:  s.zeraE      = 1'b1;
      MOSTRA:         s.mostra_mem = 1'b1;
      PROXIMO_MOSTRA: s.contaE     = 1'b1;
      INICIA_JOGADAS: begin
        s.zeraE  = 1'b1;
        s.zeraRJ = 1'b1;
      end
      REGISTRA:       s.registraRJ = 1'b1;
      PROXIMA_JOGADA: s.contaE     = 1'b1;
      PROXIMA_RODADA: s.contaR     = 1'b1;
      FIM_GANHOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
`ifdef TIMEOUT_EN
        s.db_timeout = 1'b1;
`endif
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_exp8_if.sv
// Signal bundle between the game control unit (master) and the
// datapath / top-level glue (slave).
interface unidade_controle_jogo_exp8_if;
  // start request and datapath status
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualRodada;
  logic       fimR;
  // datapath commands
  logic       zeraE;
  logic       contaE;
  logic       zeraR;
  logic       contaR;
  logic       zeraRJ;
  logic       registraRJ;
  logic       mostra_mem;
  // game result and debug
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [4:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, enderecoIgualRodada, fimR,
    output zeraE, contaE, zeraR, contaR, zeraRJ, registraRJ, mostra_mem,
    output pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, enderecoIgualRodada, fimR,
    input  zeraE, contaE, zeraR, contaR, zeraRJ, registraRJ, mostra_mem,
    input  pronto, ganhou, perdeu, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_exp8_temporizador_jogo.sv
// Shared phase timer for the game FSM: counts while enabled, clears on
// request, and stops at the selected terminal value instead of wrapping.
module temporizador_jogo
  import unidade_controle_jogo_exp8_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [TIMER_W-1:0] limite,
  output logic               fim
);

  logic [TIMER_W-1:0] valor;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor <= '0;
    end else if (conta && (valor != limite)) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == limite);

endmodule

// File: rtl/unidade_controle_jogo_exp8.sv
// Memory-game (Genius) control unit: Moore FSM sequencing the address
// and round counters, the LED show, the move register and the end flags.
// Optional feature macro: TIMEOUT_EN enables the per-move timeout that
// ends the game in fim_timeout; without it the FSM waits indefinitely.
module unidade_controle_jogo_exp8
  import unidade_controle_jogo_exp8_pkg::*;
#(
  parameter int unsigned MOSTRA_CICLOS  = 500,
  parameter int unsigned INTERV_CICLOS  = 250,
  parameter int unsigned TIMEOUT_CICLOS = 3000
) (
  input  logic                          clock,
  input  logic                          reset,
  unidade_controle_jogo_exp8_if.master  jogo
);

  localparam logic [TIMER_W-1:0] LIM_MOSTRA  = TIMER_W'(MOSTRA_CICLOS - 1);
  localparam logic [TIMER_W-1:0] LIM_INTERV  = TIMER_W'(INTERV_CICLOS - 1);
  localparam logic [TIMER_W-1:0] LIM_TIMEOUT = TIMER_W'(TIMEOUT_CICLOS - 1);

  estado_t            estado;
  estado_t            proximo;
  saidas_t            saidas;
  logic [TIMER_W-1:0] t_limite;
  logic               t_zera;
  logic               t_conta;
  logic               t_fim;

  temporizador_jogo u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .zera   (t_zera),
    .conta  (t_conta),
    .limite (t_limite),
    .fim    (t_fim)
  );

  // Timer control: runs only in show/gap/wait, cleared everywhere else.
  // Leaving mostra clears it too, so intervalo starts from zero.
  always_comb begin
    t_limite = LIM_MOSTRA;
    t_conta  = 1'b0;
    t_zera   = 1'b1;
    case (estado)
      MOSTRA: begin
        t_limite = LIM_MOSTRA;
        t_conta  = 1'b1;
        t_zera   = t_fim;
      end
      INTERVALO: begin
        t_limite = LIM_INTERV;
        t_conta  = 1'b1;
        t_zera   = 1'b0;
      end
      ESPERA_JOGADA: begin
        t_limite = LIM_TIMEOUT;
        t_conta  = 1'b1;
        t_zera   = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:        if (jogo.iniciar) proximo = PREPARACAO;
      PREPARACAO:     proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = MOSTRA;
      MOSTRA: begin
        if (t_fim) proximo = jogo.enderecoIgualRodada ? INICIA_JOGADAS : INTERVALO;
      end
      INTERVALO:      if (t_fim) proximo = PROXIMO_MOSTRA;
      PROXIMO_MOSTRA: proximo = MOSTRA;
      INICIA_JOGADAS: proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // a press in the expiry cycle still counts as a move
        if (jogo.jogada) proximo = REGISTRA;
`ifdef TIMEOUT_EN
        else if (t_fim) proximo = FIM_TIMEOUT;
`endif
      end
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!jogo.igual)                    proximo = FIM_PERDEU;
        else if (!jogo.enderecoIgualRodada) proximo = PROXIMA_JOGADA;
        else                                proximo = ULTIMA_RODADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      ULTIMA_RODADA:  proximo = jogo.fimR ? FIM_GANHOU : PROXIMA_RODADA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (jogo.iniciar) proximo = PREPARACAO;
      end
      default:        proximo = INICIAL;
    endcase
  end

  // State register; outputs are registered from the next state so they
  // always match the decode of the state they accompany.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= decodifica(INICIAL);
    end else begin
      estado <= proximo;
      saidas <= decodifica(proximo);
    end
  end

  assign jogo.zeraE      = saidas.zeraE;
  assign jogo.contaE     = saidas.contaE;
  assign jogo.zeraR      = saidas.zeraR;
  assign jogo.contaR     = saidas.contaR;
  assign jogo.zeraRJ     = saidas.zeraRJ;
  assign jogo.registraRJ = saidas.registraRJ;
  assign jogo.mostra_mem = saidas.mostra_mem;
  assign jogo.pronto     = saidas.pronto;
  assign jogo.ganhou     = saidas.ganhou;
  assign jogo.perdeu     = saidas.perdeu;
  assign jogo.db_timeout = saidas.db_timeout;
  assign jogo.db_estado  = estado;

endmodule

// File: tb/tb_unidade_controle_jogo_exp8.sv
// Bench for the memory-game control unit. A small datapath model (E, R,
// move register, random memory) answers the FSM; a scripted player plays
// games and results are predicted from game rules.
module tb_unidade_controle_jogo_exp8;

  localparam int MOSTRA = 500;
  localparam int INTERV = 250;
  localparam int TOUT   = 3000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_jogo_exp8_if jogo ();

  unidade_controle_jogo_exp8 #(
    .MOSTRA_CICLOS  (MOSTRA),
    .INTERV_CICLOS  (INTERV),
    .TIMEOUT_CICLOS (TOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .jogo  (jogo)
  );

  int total = 0;
  int bad   = 0;

  // datapath environment
  logic [3:0] mem [16];
  logic [3:0] botao = 4'd0;
  logic [3:0] e_cnt, r_cnt, rj;
  int         ultima = 15;
  int         contaR_pulsos = 0;

  always @(posedge clock) begin
    if (reset) begin
      e_cnt <= 4'd0;
      r_cnt <= 4'd0;
      rj    <= 4'd0;
    end else begin
      if (jogo.zeraE)       e_cnt <= 4'd0;
      else if (jogo.contaE) e_cnt <= e_cnt + 4'd1;
      if (jogo.zeraR)       r_cnt <= 4'd0;
      else if (jogo.contaR) r_cnt <= r_cnt + 4'd1;
      if (jogo.zeraRJ)          rj <= 4'd0;
      else if (jogo.registraRJ) rj <= botao;
      if (jogo.contaR) contaR_pulsos <= contaR_pulsos + 1;
    end
  end

  assign jogo.igual               = (rj == mem[e_cnt]);
  assign jogo.enderecoIgualRodada = (e_cnt == r_cnt);
  assign jogo.fimR                = (int'(r_cnt) == ultima);

  task automatic novo_mem();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_estado(input logic [4:0] alvo, input int limite, input string nome);
    int n = 0;
    while (jogo.db_estado !== alvo && n < limite) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (jogo.db_estado !== alvo) begin
      bad++;
      $display("FAIL %s: estado=%h esperado=%h", nome, jogo.db_estado, alvo);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_game(input bit hold);
    jogo.iniciar = 1'b1;
    @(negedge clock);
    if (!hold) jogo.iniciar = 1'b0;
    total++;
    if (jogo.db_estado !== 5'h01 || {jogo.pronto, jogo.ganhou, jogo.perdeu, jogo.db_timeout} !== 4'b0) begin
      bad++;
      $display("FAIL start: estado=%h flags=%b esperado 01/0000", jogo.db_estado,
               {jogo.pronto, jogo.ganhou, jogo.perdeu, jogo.db_timeout});
    end
    @(negedge clock);
    total++;
    if (jogo.db_estado !== 5'h02) begin
      bad++;
      $display("FAIL start_02: estado=%h esperado=02", jogo.db_estado);
    end
  endtask

  // Show phase of round r: r+1 moves lit MOSTRA cycles each, addresses 0..r
  // in order, separated by INTERV dark cycles plus one advance cycle.
  task automatic run_show(input int r);
    int  n = 0, hi = 0, pulsos = 0, dur = 0;
    bit  prev = 1'b0;
    int  budget = (r + 1) * (MOSTRA + INTERV + 2) + 20;
    while (jogo.db_estado !== 5'h06 && n < budget) begin
      if (jogo.db_estado === 5'h03 || jogo.db_estado === 5'h04 || jogo.db_estado === 5'h05) dur++;
      if (jogo.mostra_mem === 1'b1) begin
        hi++;
        if (!prev) begin
          pulsos++;
          total++;
          if (int'(e_cnt) !== pulsos - 1) begin
            bad++;
            $display("FAIL show_addr r=%0d: E=%0d esperado=%0d", r, e_cnt, pulsos - 1);
          end
        end
      end
      prev = (jogo.mostra_mem === 1'b1);
      @(negedge clock);
      n++;
    end
    total++;
    if (jogo.db_estado !== 5'h06) begin
      bad++;
      $display("FAIL show_end r=%0d: estado=%h esperado=06", r, jogo.db_estado);
    end
    total++;
    if (pulsos !== r + 1 || hi !== (r + 1) * MOSTRA) begin
      bad++;
      $display("FAIL show_leds r=%0d: pulsos=%0d hi=%0d esperado %0d/%0d", r, pulsos, hi, r + 1, (r + 1) * MOSTRA);
    end
    total++;
    if (dur !== (r + 1) * MOSTRA + r * (INTERV + 1)) begin
      bad++;
      $display("FAIL show_len r=%0d: ciclos=%0d esperado=%0d", r, dur, (r + 1) * MOSTRA + r * (INTERV + 1));
    end
  endtask

  // Player enters moves 0..r; move wrong_at (if in range) is a wrong button.
  task automatic play_round(input int r, input int wrong_at);
    for (int j = 0; j <= r; j++) begin
      wait_estado(5'h07, 8, "espera");
      if (j == wrong_at) botao = mem[j] ^ 4'(1 + $urandom_range(0, 14));
      else               botao = mem[j];
      jogo.jogada = 1'b1;
      @(negedge clock);
      jogo.jogada = 1'b0;
      total++;
      if (jogo.db_estado !== 5'h08) begin
        bad++;
        $display("FAIL registra j=%0d: estado=%h esperado=08", j, jogo.db_estado);
      end
      if (j == wrong_at) begin
        wait_estado(5'h0E, 4, "perdeu");
        return;
      end
    end
    wait_estado(5'h0B, 4, "ultima");
  endtask

  task automatic test_reset();
    jogo.iniciar = 1'b0;
    jogo.jogada  = 1'b0;
    do_reset();
    total++;
    if (jogo.db_estado !== 5'h00 ||
        {jogo.zeraE, jogo.contaE, jogo.zeraR, jogo.contaR, jogo.zeraRJ, jogo.registraRJ,
         jogo.mostra_mem, jogo.pronto, jogo.ganhou, jogo.perdeu, jogo.db_timeout} !== 11'b0) begin
      bad++;
      $display("FAIL reset: estado=%h saidas=%b esperado 00/0", jogo.db_estado,
               {jogo.zeraE, jogo.contaE, jogo.zeraR, jogo.contaR, jogo.zeraRJ, jogo.registraRJ,
                jogo.mostra_mem, jogo.pronto, jogo.ganhou, jogo.perdeu, jogo.db_timeout});
    end
  endtask

  task automatic test_round0();
    logic [4:0] seq [5] = '{5'h08, 5'h09, 5'h0B, 5'h0C, 5'h02};
    int c0;
    start_game(1'b0);
    run_show(0);
    wait_estado(5'h07, 3, "r0_espera");
    c0 = contaR_pulsos;
    botao = mem[0];
    jogo.jogada = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      jogo.jogada = 1'b0;
      total++;
      if (jogo.db_estado !== seq[i]) begin
        bad++;
        $display("FAIL r0_seq[%0d]: estado=%h esperado=%h", i, jogo.db_estado, seq[i]);
      end
    end
    total++;
    if (contaR_pulsos - c0 !== 1 || r_cnt !== 4'd1) begin
      bad++;
      $display("FAIL r0_contaR: pulsos=%0d R=%0d esperado 1/1", contaR_pulsos - c0, r_cnt);
    end
  endtask

  task automatic test_lose();
    run_show(1);
    play_round(1, 1);
    for (int i = 0; i < 20; i++) @(negedge clock);
    total++;
    if (jogo.db_estado !== 5'h0E || {jogo.pronto, jogo.ganhou, jogo.perdeu} !== 3'b101) begin
      bad++;
      $display("FAIL lose_hold: estado=%h pgp=%b esperado 0E/101", jogo.db_estado,
               {jogo.pronto, jogo.ganhou, jogo.perdeu});
    end
    start_game(1'b0);
  endtask

  task automatic test_timeout();
    int n = 0;
    run_show(0);
    @(negedge clock);
`ifdef TIMEOUT_EN
    while (jogo.db_estado === 5'h07 && n < TOUT + 50) begin
      n++;
      @(negedge clock);
    end
    total++;
    if (n !== TOUT || jogo.db_estado !== 5'h0F) begin
      bad++;
      $display("FAIL timeout: ciclos=%0d estado=%h esperado %0d/0F", n, jogo.db_estado, TOUT);
    end
    total++;
    if ({jogo.pronto, jogo.perdeu, jogo.db_timeout} !== 3'b111) begin
      bad++;
      $display("FAIL timeout_flags: ppt=%b esperado=111", {jogo.pronto, jogo.perdeu, jogo.db_timeout});
    end
`else
    while (n < 10000) begin
      n++;
      @(negedge clock);
    end
    total++;
    if (jogo.db_estado !== 5'h07 || jogo.db_timeout !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: estado=%h db_timeout=%b esperado 07/0", jogo.db_estado, jogo.db_timeout);
    end
    play_round(0, 0);
`endif
    start_game(1'b0);
    total++;
    if (jogo.db_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: db_timeout=%b esperado=0", jogo.db_timeout);
    end
  endtask

  // Press in the very last allowed cycle: the move must win over expiry.
  task automatic test_jogada_vence();
    run_show(0);
    @(negedge clock);
    repeat (TOUT - 1) @(negedge clock);
    total++;
    if (jogo.db_estado !== 5'h07) begin
      bad++;
      $display("FAIL last_cycle: estado=%h esperado=07", jogo.db_estado);
    end
    botao = mem[0];
    jogo.jogada = 1'b1;
    @(negedge clock);
    jogo.jogada = 1'b0;
    total++;
    if (jogo.db_estado !== 5'h08) begin
      bad++;
      $display("FAIL jogada_vence: estado=%h esperado=08", jogo.db_estado);
    end
    wait_estado(5'h0C, 5, "vence_0C");
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 3; g++) begin
      int k = $urandom_range(0, 2);
      int m = $urandom_range(0, k);
      bit hold = 1'($urandom_range(0, 1));
      novo_mem();
      do_reset();
      total++;
      if (jogo.db_estado !== 5'h00) begin
        bad++;
        $display("FAIL rand_reset g=%0d: estado=%h esperado=00", g, jogo.db_estado);
      end
      start_game(hold);
      for (int r = 0; r <= k; r++) begin
        run_show(r);
        play_round(r, (r == k) ? m : -1);
      end
      total++;
      if (jogo.db_estado !== 5'h0E || {jogo.pronto, jogo.ganhou, jogo.perdeu} !== 3'b101 ||
          int'(r_cnt) !== k || int'(e_cnt) !== m) begin
        bad++;
        $display("FAIL rand_game g=%0d: estado=%h pgp=%b R=%0d E=%0d esperado 0E/101/%0d/%0d",
                 g, jogo.db_estado, {jogo.pronto, jogo.ganhou, jogo.perdeu}, r_cnt, e_cnt, k, m);
      end
      jogo.iniciar = 1'b0;
    end
  endtask

  task automatic test_win();
    novo_mem();
    ultima = 1;
    do_reset();
    start_game(1'b0);
    run_show(0);
    play_round(0, -1);
    run_show(1);
    play_round(1, -1);
    wait_estado(5'h0D, 3, "ganhou");
    repeat (5) @(negedge clock);
    total++;
    if (jogo.db_estado !== 5'h0D || {jogo.pronto, jogo.ganhou, jogo.perdeu} !== 3'b110 || r_cnt !== 4'd1) begin
      bad++;
      $display("FAIL win: estado=%h pgp=%b R=%0d esperado 0D/110/1", jogo.db_estado,
               {jogo.pronto, jogo.ganhou, jogo.perdeu}, r_cnt);
    end
    jogo.iniciar = 1'b1;
    do_reset();
    jogo.iniciar = 1'b0;
    total++;
    if (jogo.db_estado !== 5'h00 || {jogo.pronto, jogo.ganhou, jogo.perdeu} !== 3'b000) begin
      bad++;
      $display("FAIL win_reset: estado=%h pgp=%b esperado 00/000", jogo.db_estado,
               {jogo.pronto, jogo.ganhou, jogo.perdeu});
    end
    ultima = 15;
  endtask

  initial begin
    jogo.iniciar = 1'b0;
    jogo.jogada  = 1'b0;
    novo_mem();
    @(negedge clock);
    test_reset();
    test_round0();
    test_lose();
    test_timeout();
    test_jogada_vence();
    test_random_games();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
